// File: rtl/pc_pkg.sv
// Shared types and constants for the PC sequencer.
// Optional trap feature: PC_MISALIGN_TRAP_EN.
package pc_pkg;

  localparam int          XLEN_D = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: jalr over taken branch over sequential.
// Optional trap feature: PC_MISALIGN_TRAP_EN (no effect here).
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_D
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] br_off,
  input  logic            br_taken,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_tgt,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4
);

  assign pc_plus4 = pc + PC_INC;

  always_comb begin
    next_pc = pc_plus4;
    priority case (1'b1)
      jalr:     next_pc = {jalr_tgt[XLEN-1:1], 1'b0};
      br_taken: next_pc = pc + br_off;
      default:  next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and fetch FSM (IDLE/FETCH/HOLD).
// Optional sticky misalignment trap: PC_MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          XLEN         = XLEN_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] br_off,
  input  logic            br_taken,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_tgt,
  input  logic            stall,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misaligned
`endif
);

  pc_state_t       state, state_n;
  logic [XLEN-1:0] pc, pc_n, next_pc;
  logic            go, bad, trap;

  pc_next_mux #(.XLEN(XLEN)) u_mux (
    .pc       (pc),
    .br_off   (br_off),
    .br_taken (br_taken),
    .jalr     (jalr),
    .jalr_tgt (jalr_tgt),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

`ifdef PC_MISALIGN_TRAP_EN
  assign bad        = next_pc[1:0] != 2'b00;
  assign misaligned = trap;

  // Once set, only reset clears the trap.
  always_ff @(posedge clk) begin
    if (!rst)
      trap <= 1'b0;
    else if (go && bad)
      trap <= 1'b1;
  end
`else
  assign bad  = 1'b0;
  assign trap = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    imem_req = 1'b0;
    go       = 1'b0;
    unique case (state)
      IDLE:  state_n = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (stall) state_n = HOLD;
          else       go      = 1'b1;
        end
      end
      HOLD:    go      = !stall && !trap;
      default: state_n = IDLE;
    endcase
    if (go) begin
      if (bad) begin
        state_n = HOLD;
      end else begin
        pc_n    = next_pc;
        state_n = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  assign pc_out    = pc;
  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table,
// reset corner cases and a randomized run against a model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] br_off = '0;
  logic        br_taken = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] jalr_tgt = '0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr, pc_out, pc_plus4;
  logic        mis;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_off     (br_off),
    .br_taken   (br_taken),
    .jalr       (jalr),
    .jalr_tgt   (jalr_tgt),
    .stall      (stall),
    .imem_ack   (imem_ack),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misaligned (mis)
`endif
  );

`ifndef PC_MISALIGN_TRAP_EN
  assign mis = 1'b0;
`endif

  typedef struct {
    logic        br_taken;
    logic        jalr;
    logic        stall;
    logic        ack;
    logic [31:0] br_off;
    logic [31:0] jalr_tgt;
    logic [31:0] exp_pc;
    logic        exp_req;
  } vec_t;

  vec_t tbl[13];

  // Reference state: started = left the post-reset cycle,
  // waiting = fetch accepted but held by stall (or trapped).
  logic [31:0] m_pc;
  bit          m_started, m_waiting, m_trap;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    br_taken = 0; jalr = 0; stall = 0; imem_ack = 0;
    br_off = 0; jalr_tgt = 0;
  endtask

  function automatic logic [31:0] target(logic [31:0] p);
    if (jalr)     return jalr_tgt & 32'hFFFF_FFFE;
    if (br_taken) return p + br_off;
    return p + 32'd4;
  endfunction

  // Advance the model over one clock edge using current inputs.
  task automatic model_edge();
    bit          adv;
    logic [31:0] t;
    if (!rst) begin
      m_pc = RV; m_started = 0; m_waiting = 0; m_trap = 0;
    end else if (!m_started) begin
      m_started = 1;
    end else begin
      t   = target(m_pc);
      adv = m_waiting ? (!stall && !m_trap) : (imem_ack && !stall);
      if (!m_waiting && imem_ack && stall) m_waiting = 1;
      if (adv) begin
        if (TRAP && t[1:0] != 2'b00) begin
          m_trap = 1; m_waiting = 1;
        end else begin
          m_pc = t; m_waiting = 0;
        end
      end
    end
  endtask

  initial begin
    // pc=0x100 in FETCH at entry to this table
    tbl[0]  = '{0,0,0,1, 32'h0,         32'h0,         32'h104,       1};
    tbl[1]  = '{0,0,0,1, 32'h0,         32'h0,         32'h108,       1};
    tbl[2]  = '{1,0,0,1, 32'hFFFF_FFF8, 32'h0,         32'h100,       1};
    tbl[3]  = '{1,1,0,1, 32'h40,        32'h2001,      32'h2000,      1};
    tbl[4]  = '{0,0,0,0, 32'h0,         32'h0,         32'h2000,      1};
    tbl[5]  = '{0,0,1,1, 32'h0,         32'h0,         32'h2000,      0};
    tbl[6]  = '{0,0,1,1, 32'h0,         32'h0,         32'h2000,      0};
    tbl[7]  = '{0,0,1,0, 32'h0,         32'h0,         32'h2000,      0};
    tbl[8]  = '{0,0,0,0, 32'h0,         32'h0,         32'h2004,      1};
    tbl[9]  = '{0,1,0,1, 32'h0,         32'hFFFF_FFFD, 32'hFFFF_FFFC, 1};
    tbl[10] = '{0,0,0,1, 32'h0,         32'h0,         32'h0,         1};
    tbl[11] = '{1,0,0,1, 32'h40,        32'h0,         32'h40,        1};
    tbl[12] = '{1,0,0,0, 32'h8,         32'h0,         32'h40,        1};

    // Reset and release
    idle_in();
    rst = 0;
    step(); step();
    chk("rst_pc", pc_out, RV);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_mis", {31'b0, mis}, 32'd0);
    rst = 1;
    stall = 1; imem_ack = 1;
    step();
    chk("first_fetch_req", {31'b0, imem_req}, 32'd1);
    chk("first_fetch_pc", pc_out, RV);

    foreach (tbl[i]) begin
      br_taken = tbl[i].br_taken; jalr = tbl[i].jalr;
      stall = tbl[i].stall; imem_ack = tbl[i].ack;
      br_off = tbl[i].br_off; jalr_tgt = tbl[i].jalr_tgt;
      step();
      chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_p4", i), pc_plus4, tbl[i].exp_pc + 32'd4);
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req},
          {31'b0, tbl[i].exp_req});
    end

    // Reset mid-fetch at 0x40, late ack must be ignored
    idle_in();
    rst = 0;
    step();
    chk("midrst_pc", pc_out, RV);
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    rst = 1; imem_ack = 1; br_taken = 1; br_off = 32'h20;
    step();
    chk("lateack_pc", pc_out, RV);
    chk("lateack_req", {31'b0, imem_req}, 32'd1);

    // Misaligned branch target from 0x100
    br_off = 32'h6;
    step();
    if (TRAP) begin
      chk("mis_pc", pc_out, RV);
      chk("mis_flag", {31'b0, mis}, 32'd1);
      chk("mis_req", {31'b0, imem_req}, 32'd0);
      stall = 0; br_off = 32'h4;
      repeat (3) step();
      chk("mis_hold_pc", pc_out, RV);
      chk("mis_hold_req", {31'b0, imem_req}, 32'd0);
      chk("mis_hold_flag", {31'b0, mis}, 32'd1);
    end else begin
      chk("unal_pc", pc_out, RV + 32'h6);
      chk("unal_req", {31'b0, imem_req}, 32'd1);
    end

    // Randomized run against the reference model
    idle_in();
    rst = 0;
    model_edge();
    step();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 49) != 0);
      imem_ack = $urandom_range(0, 3) != 0;
      stall    = $urandom_range(0, 3) == 0;
      br_taken = $urandom_range(0, 3) == 0;
      jalr     = $urandom_range(0, 7) == 0;
      br_off   = $urandom & 32'hFFFF_FFFC;
      jalr_tgt = $urandom & 32'hFFFF_FFFD;
      if ($urandom_range(0, 15) == 0) br_off[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) jalr_tgt[1] = 1'b1;
      model_edge();
      step();
      chk("rnd_pc", pc_out, m_pc);
      chk("rnd_p4", pc_plus4, m_pc + 32'd4);
      chk("rnd_req", {31'b0, imem_req},
          {31'b0, m_started && !m_waiting});
      if (TRAP) chk("rnd_mis", {31'b0, mis}, {31'b0, m_trap});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
